// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the two-channel SRAM port arbiter.
package sram_port_arbiter_pkg;

    // Response owner encoding
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
    localparam int unsigned STARVE_CNT_W         = 4;

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates an instruction-read channel and a data read/write channel onto one
// single-cycle-latency SRAM port. Data has priority; inst is forced through
// after STARVE_LIMIT consecutive denied cycles.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W-1:0] starve_cnt_next;
    logic                    resp_vld;
    logic                    resp_own;
    logic                    inst_gnt;
    logic                    data_gnt;

    // Grant decision; reset blocks any grant combinationally
    always_comb begin
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        if (!reset) begin
            inst_gnt = inst_req && (!data_req || (starve_cnt == LIMIT));
            data_gnt = data_req && !inst_gnt;
        end
    end

    // Drive the shared SRAM port from the winning channel, zero when idle
    always_comb begin
        sram_en    = inst_gnt | data_gnt;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (data_gnt) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            sram_wen   = {4{data_wr}} & data_wstrb;
        end else if (inst_gnt) begin
            sram_addr  = inst_addr;
        end
    end

    // Starvation counter: count denied inst cycles, saturating at the limit
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!inst_req || inst_gnt) begin
            starve_cnt_next = '0;
        end else if (starve_cnt < LIMIT) begin
            starve_cnt_next = starve_cnt + 1'b1;
        end
    end

    // Response tracker and starvation state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            resp_vld   <= 1'b0;
            resp_own   <= OWN_INST;
        end else begin
            starve_cnt <= starve_cnt_next;
            resp_vld   <= sram_en;
            resp_own   <= data_gnt ? OWN_DATA : OWN_INST;
        end
    end

    // Handshake and response outputs
    always_comb begin
        inst_addr_ok = inst_gnt;
        data_addr_ok = data_gnt;
        inst_data_ok = resp_vld && (resp_own == OWN_INST);
        data_data_ok = resp_vld && (resp_own == OWN_DATA);
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int tests = 0;
    int fails = 0;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    // SRAM behaviour: read-before-write, data one cycle after enable, junk otherwise
    logic [31:0] sram_mem [16];
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr[5:2]];
            sram_mem[sram_addr[5:2]] = merge(sram_mem[sram_addr[5:2]], sram_wdata, sram_wen);
        end else begin
            sram_rdata <= $urandom;
        end
    end

    // Transaction-level model state
    logic [31:0] m_mem [16];
    int          m_denied = 0;
    bit          pend_vld = 0;
    bit          pend_data = 0;
    bit          pend_read = 0;
    logic [31:0] pend_rdata = '0;
    bit          acc_i = 0;
    bit          acc_d = 0;

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        bit          wi;
        bit          wd;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  ewe;
        if (reset) begin
            check("rst_sram_en", 32'(sram_en), 32'd0);
            check("rst_sram_wen", 32'(sram_wen), 32'd0);
            check("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
            check("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            m_denied = 0;
            pend_vld = 0;
            acc_i    = 0;
            acc_d    = 0;
        end else begin
            wi  = inst_req && (!data_req || m_denied == LIMIT);
            wd  = data_req && !wi;
            ea  = wd ? data_addr : (wi ? inst_addr : 32'h0);
            ewd = wd ? data_wdata : 32'h0;
            ewe = (wd && data_wr) ? data_wstrb : 4'b0000;
            check("inst_addr_ok", 32'(inst_addr_ok), 32'(wi));
            check("data_addr_ok", 32'(data_addr_ok), 32'(wd));
            check("sram_en", 32'(sram_en), 32'(wi | wd));
            check("sram_addr", sram_addr, ea);
            check("sram_wdata", sram_wdata, ewd);
            check("sram_wen", 32'(sram_wen), 32'(ewe));
            check("inst_data_ok", 32'(inst_data_ok), 32'(pend_vld && !pend_data));
            check("data_data_ok", 32'(data_data_ok), 32'(pend_vld && pend_data));
            if (pend_vld && pend_read)
                check("rdata", pend_data ? data_rdata : inst_rdata, pend_rdata);
            // Advance model to next cycle
            pend_vld  = wi | wd;
            pend_data = wd;
            pend_read = wi || (wd && !data_wr);
            if (wi | wd) pend_rdata = m_mem[ea[5:2]];
            if (wd && data_wr) m_mem[ea[5:2]] = merge(m_mem[ea[5:2]], data_wdata, data_wstrb);
            if (inst_req && !wi) m_denied = (m_denied < LIMIT) ? m_denied + 1 : LIMIT;
            else m_denied = 0;
            acc_i = wi;
            acc_d = wd;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
        inst_addr = 0; data_addr = 0; data_wdata = 0;
    endtask

    logic [9:0] inst_pat;
    int         cnt_i;
    int         cnt_d;

    initial begin
        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = 32'hA000_0000 + 32'(i);
            m_mem[i]    = 32'hA000_0000 + 32'(i);
        end
        sram_rdata = '0;
        idle();
        reset = 1;
        @(negedge clk);
        check("reset_sram_addr", sram_addr, 32'h0);
        next_cycle();
        next_cycle();
        reset = 0;

        // Idle: nothing enabled, port zeroed
        @(negedge clk);
        check("idle_en", 32'(sram_en), 32'd0);
        check("idle_addr", sram_addr, 32'h0);
        next_cycle();

        // Inst-only stream
        cnt_i = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                inst_req  = 1;
                inst_addr = 32'h100 + 32'(4 * i);
            end else begin
                inst_req = 0;
            end
            @(negedge clk);
            if (inst_addr_ok) cnt_i++;
            check("stream_dok", {30'd0, inst_data_ok, data_data_ok}, (i >= 1 && i <= 3) ? 32'd2 : 32'd0);
            if (i == 2) check("stream_rdata_104", inst_rdata, 32'hA000_0001);
            next_cycle();
        end
        check("stream_grants", 32'(cnt_i), 32'd3);

        // Contention with both requests held for 10 cycles
        inst_req = 1; inst_addr = 32'h20; data_req = 1; data_addr = 32'h24; data_wr = 0;
        cnt_d = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            inst_pat[i] = inst_addr_ok;
            if (data_addr_ok) cnt_d++;
            next_cycle();
        end
        check("starve_pattern", 32'(inst_pat), 32'h210);
        check("starve_data_wins", 32'(cnt_d), 32'd8);
        idle();
        next_cycle();

        // Partial write then read back
        data_req = 1; data_wr = 1; data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF;
        data_wstrb = 4'b0011;
        @(negedge clk);
        check("wr_wen", 32'(sram_wen), 32'h3);
        check("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
        next_cycle();
        data_wr = 0; data_wstrb = 0;
        @(negedge clk);
        check("wr_done", 32'(data_data_ok), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("rd_back", data_rdata, 32'hA000_BEEF);
        next_cycle();

        // Interleaved: data read, then inst read
        data_req = 1; data_addr = 32'h8;
        next_cycle();
        data_req = 0; inst_req = 1; inst_addr = 32'hC;
        @(negedge clk);
        check("il_data_ok", 32'(data_data_ok), 32'd1);
        check("il_data_rdata", data_rdata, 32'hA000_0002);
        next_cycle();
        inst_req = 0;
        @(negedge clk);
        check("il_inst_ok", 32'(inst_data_ok), 32'd1);
        check("il_inst_rdata", inst_rdata, 32'hA000_0003);
        next_cycle();

        // Reset right after a grant discards the response
        data_req = 1; data_addr = 32'h10;
        next_cycle();
        idle();
        reset = 1;
        @(negedge clk);
        check("rst_no_dok", 32'(data_data_ok), 32'd0);
        next_cycle();
        reset = 0;
        inst_req = 1; inst_addr = 32'h14;
        next_cycle();
        inst_req = 0;
        @(negedge clk);
        check("post_rst_rdata", inst_rdata, 32'hA000_0005);
        check("post_rst_ok", 32'(inst_data_ok), 32'd1);
        next_cycle();

        // Randomized traffic obeying hold-until-accepted
        for (int c = 0; c < 3000; c++) begin
            if (reset) begin
                reset = ($urandom_range(0, 1) == 0);
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1;
            end
            if (!reset) begin
                if (acc_i || !inst_req) begin
                    inst_req  = ($urandom_range(0, 99) < 60);
                    inst_addr = $urandom & 32'hFFFF_FFFC;
                end
                if (acc_d || !data_req) begin
                    data_req   = ($urandom_range(0, 99) < 50);
                    data_wr    = $urandom_range(0, 1) == 1;
                    data_wstrb = 4'($urandom);
                    data_addr  = $urandom & 32'hFFFF_FFFC;
                    data_wdata = $urandom;
                end
            end
            next_cycle();
        end
        reset = 0;
        idle();
        next_cycle();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
